serial_add: RTL and testbench

//   Multi-cycle ripple-carry adder: the addition counterpart of the ALU's 32-bit

---
 rtl/serial_add_pkg.sv | 19 +
 rtl/serial_add_if.sv | 30 +++
 rtl/serial_add_chunk.sv | 27 ++
 rtl/serial_add.sv | 144 ++++++++++++++
 tb/tb_serial_add.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the multi-cycle ripple-carry adder.
// Holds the FSM state encoding, the default geometry and the 1-bit full adder cell.
package serial_add_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Returns {carry_out, sum} of a single bit position.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    full_add = {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/serial_add_if.sv
// Operand/result handshake bundle for serial_add.
// The master modport is the producer/consumer side; the slave modport is the adder itself.
interface serial_add_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             of;

  modport master (
    output in_valid, A, B, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, of
  );

  modport slave (
    input  in_valid, A, B, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, of
  );

endinterface

// File: rtl/serial_add_chunk.sv
// Combinational CHUNK-bit ripple adder built from full adder cells.
// Also exposes the carry into the slice MSB so the caller can derive signed overflow.
module serial_add_chunk
  import serial_add_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign {c_s[i+1], s[i]} = full_add(a[i], b[i], c_s[i]);
  end

  assign cout  = c_s[CHUNK];
  assign c_msb = c_s[CHUNK-1];

endmodule

// File: rtl/serial_add.sv
// Multi-cycle adder: computes A + B + c_in one CHUNK-bit slice per clock.
// Operands are latched on accept; the published result only changes when a new add completes.
module serial_add
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic         clk,
  input  logic         rst,
  serial_add_if.slave  bus
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("serial_add: WIDTH must be a multiple of CHUNK");
  end

  typedef logic [N-1:0][CHUNK-1:0] slices_t;

  state_e           state_q, state_d;
  slices_t          a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             of_q, of_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [CHUNK-1:0] slice_sum_s;
  logic             slice_cout_s;
  logic             slice_cmsb_s;
  slices_t          acc_next_s;

  serial_add_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_q[cnt_q]),
    .b     (b_q[cnt_q]),
    .cin   (carry_q),
    .s     (slice_sum_s),
    .cout  (slice_cout_s),
    .c_msb (slice_cmsb_s)
  );

  // Next-state and datapath: accept in IDLE, one slice per RUN cycle, hold in DONE.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    c_out_d     = c_out_q;
    of_d        = of_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    acc_next_s  = acc_q;
    acc_next_s[cnt_q] = slice_sum_s;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d        = bus.A;
          b_d        = bus.B;
          carry_d    = bus.c_in;
          acc_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_RUN;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d   = acc_next_s;
        carry_d = slice_cout_s;
        cnt_d   = cnt_q + CNT_W'(1);
        // The final slice publishes the whole result at once so outputs never show partial sums.
        if (cnt_q == CNT_W'(N - 1)) begin
          sum_d       = acc_next_s;
          c_out_d     = slice_cout_s;
          of_d        = slice_cout_s ^ slice_cmsb_s;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          state_d     = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State, operand, accumulator and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      of_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      of_q        <= of_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.of        = of_q;

endmodule

// File: tb/tb_serial_add.sv
// Directed and randomised checks of serial_add at WIDTH=32, CHUNK=4.
module tb_serial_add;
  import serial_add_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  serial_add_if #(.WIDTH(32)) bus ();

  serial_add #(.WIDTH(32), .CHUNK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present operands, wait for the accept edge, then scramble inputs to prove they are latched.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic ci);
    @(negedge clk);
    check("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.c_in     = ci;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A        = $urandom;
    bus.B        = $urandom;
    bus.c_in     = 1'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 40);
  endtask

  task automatic drain();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("drain_out_valid", 64'(bus.out_valid), 64'd0);
  endtask

  task automatic run_dir(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic [31:0] es, input logic ec, input logic eo);
    int lat;
    start_op(a, b, ci);
    wait_result(lat);
    check({tag, "_latency"}, 64'(lat), 64'd8);
    check({tag, "_sum"}, 64'(bus.sum), 64'(es));
    check({tag, "_c_out"}, 64'(bus.c_out), 64'(ec));
    check({tag, "_of"}, 64'(bus.of), 64'(eo));
    drain();
  endtask

  initial begin
    int          lat;
    logic [31:0] ra, rb, es;
    logic        rc, eo;
    logic [32:0] ref_sum;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.c_in      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum", 64'(bus.sum), 64'd0);
    check("rst_c_out", 64'(bus.c_out), 64'd0);
    check("rst_of", 64'(bus.of), 64'd0);
    rst = 1'b0;

    run_dir("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_dir("sovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_dir("negovf", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1, 1'b1);

    // Backpressure: result must hold and a stray in_valid must be ignored.
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_result(lat);
    check("bp_latency", 64'(lat), 64'd8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_sum", 64'(bus.sum), 64'h2345_6789);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      bus.in_valid = (i == 2);
      bus.A        = 32'hFFFF_FFFF;
      bus.B        = 32'hFFFF_FFFF;
      bus.c_in     = 1'b1;
    end
    @(negedge clk);
    check("bp_sum_end", 64'(bus.sum), 64'h2345_6789);
    bus.in_valid = 1'b0;
    drain();
    run_dir("after_bp", 32'h0000_0005, 32'h0000_0006, 1'b0, 32'h0000_000B, 1'b0, 1'b0);

    // Reset while slice 3 is being processed.
    start_op(32'h1234_5678, 32'h0000_0001, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_sum", 64'(bus.sum), 64'd0);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("midrst_no_result", 64'(bus.out_valid), 64'd0);
    end
    run_dir("post_rst", 32'h0000_FFFF, 32'h0000_0001, 1'b1, 32'h0001_0001, 1'b0, 1'b0);

    // Random operands with random idle gaps and consumer stalls.
    for (int n = 0; n < 200; n++) begin
      ra      = $urandom;
      rb      = $urandom;
      rc      = 1'($urandom);
      ref_sum = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      es      = ref_sum[31:0];
      eo      = (ra[31] == rb[31]) && (es[31] != ra[31]);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_op(ra, rb, rc);
      wait_result(lat);
      check("rnd_latency", 64'(lat), 64'd8);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check("rnd_sum", 64'(bus.sum), 64'(es));
      check("rnd_c_out", 64'(bus.c_out), 64'(ref_sum[32]));
      check("rnd_of", 64'(bus.of), 64'(eo));
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
